// File: rtl/bpm2per.sv
// Converts a BPM value to a beat period in time-pulse units with a sequential
// restoring divider, and derives a metronome strobe from that period.
module bpm2per #(
    parameter int unsigned CLK_PER_NS = 40,
    parameter int unsigned TP_CYCLE   = 5120,
    parameter int unsigned BPM_MAX    = 250,
    localparam longint unsigned K     = 64'd60_000_000_000 / (64'(TP_CYCLE) * 64'(CLK_PER_NS)),
    localparam int unsigned PER_W     = $clog2(K + 1),
    localparam int unsigned BPM_W     = $clog2(BPM_MAX + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [BPM_W-1:0] bpm_i,
    input  logic             bpm_valid_i,
    input  logic             tp_i,
    output logic             busy_o,
    output logic [PER_W-1:0] per_o,
    output logic             per_valid_o,
    output logic             beat_o
);

    localparam int unsigned W     = PER_W + BPM_W;
    localparam int unsigned CNT_W = $clog2(PER_W + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [W-1:0]     rem, dsh, rem_sub;
    logic [PER_W-2:0] quo;
    logic [CNT_W-1:0] iter;
    logic [BPM_W-1:0] divisor;
    logic [PER_W-1:0] beat_cnt;
    logic             ge, last_iter, beat_hit;

    always_comb begin
        if (bpm_i == '0)
            divisor = BPM_W'(1);
        else if (bpm_i > BPM_W'(BPM_MAX))
            divisor = BPM_W'(BPM_MAX);
        else
            divisor = bpm_i;
    end

    assign ge        = (rem >= dsh);
    assign rem_sub   = rem - dsh;
    // iter is decremented on the same edge, so it reaches 0 as we leave S_COMPUTE
    assign last_iter = (iter == CNT_W'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (bpm_valid_i) state_nxt = S_COMPUTE;
            S_COMPUTE: if (last_iter)   state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // quo holds the first PER_W-1 quotient bits; the last bit joins it straight into per_o
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem   <= '0;
            dsh   <= '0;
            quo   <= '0;
            iter  <= '0;
            per_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bpm_valid_i) begin
                        rem  <= W'(K);
                        dsh  <= W'(divisor) << (PER_W - 1);
                        quo  <= '0;
                        iter <= CNT_W'(PER_W);
                    end
                end
                S_COMPUTE: begin
                    if (ge)
                        rem <= rem_sub;
                    dsh  <= dsh >> 1;
                    quo  <= {quo[PER_W-3:0], ge};
                    iter <= iter - 1'b1;
                    if (last_iter)
                        per_o <= {quo, ge};
                end
                default: ;
            endcase
        end
    end

    assign beat_hit = tp_i && (per_o != '0) && (beat_cnt == per_o - 1'b1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            beat_cnt <= '0;
        else if (state == S_DONE)
            beat_cnt <= '0;
        else if (tp_i && (per_o != '0))
            beat_cnt <= beat_hit ? '0 : beat_cnt + 1'b1;
    end

    assign beat_o      = beat_hit && (state != S_DONE);
    assign busy_o      = (state == S_COMPUTE);
    assign per_valid_o = (state == S_DONE);

endmodule

// File: doc/bpm2per.md
Name: bpm2per

Overview:
- Inverse of the tempo-measurement path: takes a BPM value and produces the beat period in time-pulse units, (MIN_NS/(TP_CYCLE*CLK_PER_NS))/bpm, using a sequential restoring divider.
- Also generates a metronome beat strobe from that period by counting time-pulse ticks from the timepulse block.
- Sits between the BPM source (per2bpm output or a user setting) and the LED/PWM beat indicator.

Parameters:
- CLK_PER_NS, 40, system clock period in ns.
- TP_CYCLE, 5120, clock cycles per time pulse.
- BPM_MAX, 250, highest accepted BPM; larger inputs are clamped to this.
- Derived K = 60_000_000_000/(TP_CYCLE*CLK_PER_NS), integer truncated. Default K = 292968.
- Derived PER_W = $clog2(K+1). Default PER_W = 19.
- Derived BPM_W = $clog2(BPM_MAX+1). Default BPM_W = 8.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset: asynchronous, active-high. Clock is clk_i.
- bpm_i  in  BPM_W  requested tempo.
- bpm_valid_i  in  1  one-cycle request strobe.
- tp_i  in  1  time pulse, one clk_i wide, every TP_CYCLE clocks.
- busy_o  out  1  high while a division is in progress.
- per_o  out  PER_W  registered beat period in tp_i units.
- per_valid_o  out  1  one-cycle strobe marking a new per_o.
- beat_o  out  1  one-cycle metronome strobe, coincident with a tp_i.

Behaviour:
- Reset values: per_o=0, per_valid_o=0, busy_o=0, beat_o=0, beat counter=0, FSM in S_IDLE. Reset mid-division aborts it, and no per_valid_o is produced.
- FSM states: S_IDLE, S_COMPUTE, S_DONE. The unused encoding returns to S_IDLE.
  - S_IDLE -> S_COMPUTE when bpm_valid_i=1.
  - S_COMPUTE -> S_DONE when the iteration counter reaches 0.
  - S_DONE -> S_IDLE unconditionally.
- Input clamping at load in S_IDLE:
  - divisor = 1 if bpm_i==0.
  - divisor = BPM_MAX if bpm_i>BPM_MAX.
  - otherwise divisor = bpm_i.
  - remainder = K, quotient = 0, iteration counter = PER_W.
- Divider:
  - Restoring divider, one quotient bit per cycle, MSB first, PER_W cycles.
  - The divisor is aligned at bit PER_W-1 and shifted right each cycle.
  - Working registers are PER_W+BPM_W bits wide so no overflow occurs.
  - The result is the exact integer floor(K/divisor).
- Latency and handshake:
  - If bpm_valid_i is sampled high in cycle N, busy_o is high in cycles N+1..N+PER_W (S_COMPUTE).
  - The FSM is in S_DONE in cycle N+PER_W+1, which is N+20 at defaults.
  - In S_DONE, per_o takes the quotient and per_valid_o=1 for that cycle only. per_o holds its value until the next S_DONE.
  - bpm_valid_i is ignored in S_COMPUTE and S_DONE; no queuing. A new request is accepted again in the S_IDLE cycle after S_DONE.
- Beat generator:
  - Disabled while per_o==0 (the state after reset); beat_o stays 0.
  - Otherwise, on each tp_i the counter increments. When counter==per_o-1 and tp_i=1, beat_o=1 for that cycle and the counter returns to 0.
  - Counter width is PER_W. It never exceeds per_o-1, so it cannot wrap.
  - In the S_DONE cycle the counter is cleared, restarting the beat phase. If tp_i coincides with S_DONE, the clear wins and beat_o=0 that cycle.
  - per_o=1 gives beat_o on every tp_i.
- Counts at defaults, as tp_i pulses between beats:
  - bpm 120 -> 2441.
  - bpm 60 -> 4882.
  - bpm 250 -> 1171.
  - bpm 1 -> 292968.

Test Plan:
- Reset, then hold tp_i pulsing -> per_o=0, beat_o never asserts, busy_o=0.
- bpm_i=120 strobe at cycle N -> busy_o high N+1..N+19, per_valid_o only at N+20, per_o=2441. Then beat_o exactly every 2441st tp_i.
- bpm_i=0 -> per_o=292968. bpm_i=255 -> per_o=1171 (clamped to 250). bpm_i=1 -> per_o=292968.
- Second strobe (bpm_i=60) during busy_o -> ignored, per_o=2441. The same strobe in S_IDLE afterwards -> per_o=4882, with the beat counter restarted at S_DONE.
- tp_i coincident with S_DONE -> no beat that cycle. The first beat follows per_o tp_i pulses later.
- rst_i asserted mid S_COMPUTE -> all outputs return to 0 immediately, and no per_valid_o occurs after release.
- Sweep bpm 1..250 -> per_o==floor(292968/bpm) for every value.
